// File: rtl/fp_rf_pkg.sv
// Shared types and default sizes for the FP register file with scoreboard.
// The clear sequencer state lives here so the top and the bench agree on names.
package fp_rf_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_t;

endpackage

// File: rtl/fp_rf_scoreboard.sv
// Per-register busy bits for the issue stage: allocation sets, writeback clears,
// and each lookup is masked by a same-cycle writeback to that register.
module fp_rf_scoreboard
  import fp_rf_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_addr,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_addr,
  input  logic [ADDR_WIDTH-1:0] addr_A,
  input  logic [ADDR_WIDTH-1:0] addr_B,
  input  logic [ADDR_WIDTH-1:0] addr_C,
  output logic                  busy_A,
  output logic                  busy_B,
  output logic                  busy_C
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // The set is applied after the clear so a new producer supersedes the writeback.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en) busy_d[set_addr] = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_A = busy_q[addr_A] & ~(clr_en && (clr_addr == addr_A));
  assign busy_B = busy_q[addr_B] & ~(clr_en && (clr_addr == addr_B));
  assign busy_C = busy_q[addr_C] & ~(clr_en && (clr_addr == addr_C));

endmodule

// File: rtl/fp_regfile_sb.sv
// Three-read, one-write FP register file with write-to-read bypass, a busy
// scoreboard and a post-reset sequencer that zeroes every entry before use.
module fp_regfile_sb
  import fp_rf_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [ADDR_WIDTH-1:0] addr_A,
  input  logic [ADDR_WIDTH-1:0] addr_B,
  input  logic [ADDR_WIDTH-1:0] addr_C,
  output logic [DATA_WIDTH-1:0] data_outA,
  output logic [DATA_WIDTH-1:0] data_outB,
  output logic [DATA_WIDTH-1:0] data_outC,
  output logic                  busy_A,
  output logic                  busy_B,
  output logic                  busy_C,
  input  logic                  write_En,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  alloc_En,
  input  logic [ADDR_WIDTH-1:0] alloc_Addr,
  output logic                  init_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  rf_state_t             state, state_next;
  logic [ADDR_WIDTH-1:0] clr_ptr, clr_ptr_next;
  logic                  clr_we;
  logic                  ready;
  logic                  wr_en;
  logic                  alloc_en;
  logic                  hit_A, hit_B, hit_C;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    clr_we       = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_we       = 1'b1;
        clr_ptr_next = clr_ptr + 1'b1;
        if (clr_ptr == '1) state_next = READY;
      end
      READY: begin
        state_next = READY;
      end
    endcase
  end

  assign ready     = (state == READY);
  assign init_done = ready;

  // Writeback and allocation are only honoured once the array has been zeroed.
  assign wr_en    = write_En & ready;
  assign alloc_en = alloc_En & ready;

  // The array has no reset; the sequencer owns the write port during CLEAR.
  always_ff @(posedge Clk) begin
    if (clr_we)     mem[clr_ptr]   <= '0;
    else if (wr_en) mem[writeAddr] <= data_in;
  end

  assign hit_A = wr_en && (writeAddr == addr_A);
  assign hit_B = wr_en && (writeAddr == addr_B);
  assign hit_C = wr_en && (writeAddr == addr_C);

  assign data_outA = !ready ? '0 : (hit_A ? data_in : mem[addr_A]);
  assign data_outB = !ready ? '0 : (hit_B ? data_in : mem[addr_B]);
  assign data_outC = !ready ? '0 : (hit_C ? data_in : mem[addr_C]);

  fp_rf_scoreboard #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_scoreboard (
    .Clk      (Clk),
    .Rst_n    (Rst_n),
    .set_en   (alloc_en),
    .set_addr (alloc_Addr),
    .clr_en   (wr_en),
    .clr_addr (writeAddr),
    .addr_A   (addr_A),
    .addr_B   (addr_B),
    .addr_C   (addr_C),
    .busy_A   (busy_A),
    .busy_B   (busy_B),
    .busy_C   (busy_C)
  );

endmodule
